// File: rtl/nibble_bas_arbiter.sv
// nibble_bas_arbiter: round-robin arbiter sharing one 4-bit add/sub unit between two requesters.
// Define NIBBLE_BAS_SAT_EN to saturate results on signed overflow.
module nibble_bas_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       m0,
  input  logic       m1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] res0,
  output logic [3:0] res1,
  output logic       c0,
  output logic       c1,
  output logic       v0,
  output logic       v1,
  output logic [7:0] cnt0,
  output logic [7:0] cnt1,
  output logic [3:0] bas_a,
  output logic [3:0] bas_b,
  output logic       bas_m,
  input  logic [3:0] bas_s,
  input  logic       bas_c,
  input  logic       bas_v
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t     state_q, state_d;
  logic [2:0] tmr_q;
  logic       own_q, last_q, m_q;
  logic [3:0] a_q, b_q, rn;
  logic [3:0] res0_q, res1_q;
  logic       c0_q, c1_q, v0_q, v1_q;
  logic [7:0] cnt0_q, cnt1_q;
  logic       win1, g0, g1, cap;
  // requester 1 wins a tie only when requester 0 was served last
  assign win1 = req1 & (~req0 | ~last_q);
  always_comb begin
    state_d = state_q;
    g0 = 1'b0;
    g1 = 1'b0;
    cap = 1'b0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        g1 = win1;
        g0 = ~win1;
        state_d = ISSUE;
      end
      ISSUE: if (tmr_q == 3'd0) begin
        cap = 1'b1;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef NIBBLE_BAS_SAT_EN
  assign rn = bas_v ? (a_q[3] ? 4'b1000 : 4'b0111) : bas_s;
`else
  assign rn = bas_s;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      tmr_q <= 3'd0;
      own_q <= 1'b0;
      last_q <= 1'b1;
      a_q <= 4'd0;
      b_q <= 4'd0;
      m_q <= 1'b0;
      res0_q <= 4'd0;
      res1_q <= 4'd0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (g0 | g1) begin
        own_q <= g1;
        last_q <= g1;
        a_q <= g1 ? a1 : a0;
        b_q <= g1 ? b1 : b0;
        m_q <= g1 ? m1 : m0;
        tmr_q <= 3'(SETTLE - 1);
      end else if (state_q == ISSUE) tmr_q <= tmr_q - 3'd1;
      // results land on the capture edge so they are valid alongside done
      if (cap & ~own_q) begin
        res0_q <= rn;
        c0_q <= bas_c;
        v0_q <= bas_v;
        cnt0_q <= cnt0_q + 8'd1;
      end
      if (cap & own_q) begin
        res1_q <= rn;
        c1_q <= bas_c;
        v1_q <= bas_v;
        cnt1_q <= cnt1_q + 8'd1;
      end
    end
  assign gnt0  = g0 & ~rst;
  assign gnt1  = g1 & ~rst;
  assign done0 = (state_q == RESP) & ~own_q;
  assign done1 = (state_q == RESP) & own_q;
  assign bas_a = (state_q == ISSUE) ? a_q : 4'd0;
  assign bas_b = (state_q == ISSUE) ? b_q : 4'd0;
  assign bas_m = (state_q == ISSUE) & m_q;
  assign res0  = res0_q;
  assign res1  = res1_q;
  assign c0    = c0_q;
  assign c1    = c1_q;
  assign v0    = v0_q;
  assign v1    = v1_q;
  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;
endmodule

// File: tb/tb_nibble_bas_arbiter.sv
// tb_nibble_bas_arbiter: table, directed and random checks of nibble_bas_arbiter against a behavioural model.
module tb_nibble_bas_arbiter;
  localparam int SETTLE = 3;
`ifdef NIBBLE_BAS_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, req1 = 0, m0 = 0, m1 = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic gnt0, gnt1, done0, done1, c0, c1, v0, v1, bas_m, bas_c, bas_v;
  logic [3:0] res0, res1, bas_a, bas_b, bas_s;
  logic [7:0] cnt0, cnt1;
  int vectors = 0, miscompares = 0;
  logic [3:0] e_res [2];
  logic       e_c [2], e_v [2];
  logic [7:0] e_cnt [2];

  nibble_bas_arbiter #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .m0(m0), .m1(m1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .res0(res0), .res1(res1), .c0(c0), .c1(c1),
    .v0(v0), .v1(v1), .cnt0(cnt0), .cnt1(cnt1), .bas_a(bas_a), .bas_b(bas_b),
    .bas_m(bas_m), .bas_s(bas_s), .bas_c(bas_c), .bas_v(bas_v));

  always #5 clk = ~clk;

  function automatic logic [5:0] raw(input logic [3:0] a, input logic [3:0] b, input logic m);
    int sa, sb, r;
    logic c;
    sa = $signed(a);
    sb = $signed(b);
    r = m ? sa - sb : sa + sb;
    c = m ? (a >= b) : ((int'(a) + int'(b)) > 15);
    return {r[3:0], c, (r > 7 || r < -8)};
  endfunction

  function automatic logic [5:0] expect_of(input logic [3:0] a, input logic [3:0] b, input logic m);
    logic [5:0] x;
    x = raw(a, b, m);
    if (SAT && x[0]) x[5:2] = a[3] ? 4'b1000 : 4'b0111;
    return x;
  endfunction

  always_comb {bas_s, bas_c, bas_v} = raw(bas_a, bas_b, bas_m);

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_state();
    chk("res0", res0, e_res[0]);
    chk("c0v0", {c0, v0}, {e_c[0], e_v[0]});
    chk("cnt0", cnt0, e_cnt[0]);
    chk("res1", res1, e_res[1]);
    chk("c1v1", {c1, v1}, {e_c[1], e_v[1]});
    chk("cnt1", cnt1, e_cnt[1]);
  endtask

  task automatic model_done(input bit w, input logic [3:0] a, input logic [3:0] b, input logic m);
    {e_res[w], e_c[w], e_v[w]} = expect_of(a, b, m);
    e_cnt[w] = e_cnt[w] + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 0;
    req1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_res[i] = 0;
      e_c[i] = 0;
      e_v[i] = 0;
      e_cnt[i] = 0;
    end
  endtask

  task automatic do_op(input bit w, input logic [3:0] a, input logic [3:0] b, input logic m,
                       output logic [5:0] got);
    int k;
    if (w) begin req1 = 1; a1 = a; b1 = b; m1 = m; end
    else begin req0 = 1; a0 = a; b0 = b; m0 = m; end
    k = 0;
    #1;
    while (!(w ? gnt1 : gnt0) && k < 20) begin @(negedge clk); #1; k++; end
    chk("gnt_timeout", k < 20, 1'b1);
    chk("gnt_other", w ? gnt0 : gnt1, 1'b0);
    chk("bas_idle", {bas_a, bas_b, bas_m}, 9'd0);
    @(posedge clk);
    @(negedge clk);
    if (w) begin req1 = 0; a1 = 4'($urandom); b1 = 4'($urandom); m1 = 1'($urandom); end
    else begin req0 = 0; a0 = 4'($urandom); b0 = 4'($urandom); m0 = 1'($urandom); end
    chk("bas_issue", {bas_a, bas_b, bas_m}, {a, b, m});
    k = 1;
    while (!(w ? done1 : done0) && k < 20) begin @(negedge clk); k++; end
    chk("latency", k, SETTLE + 1);
    chk("done_other", w ? done0 : done1, 1'b0);
    model_done(w, a, b, m);
    chk_state();
    got = w ? {res1, c1, v1} : {res0, c0, v0};
  endtask

  typedef struct {
    bit w;
    logic [3:0] a, b;
    logic m;
    logic [3:0] er;
    logic ec, ev;
  } vec_t;

  initial begin
    vec_t tbl [7];
    logic [5:0] got;
    int k, dn;
    bit w;
    logic [3:0] ra, rb;
    logic rm;
    tbl[0] = '{0, 4'd3, 4'd4, 0, 4'b0111, 0, 0};
    tbl[1] = '{1, 4'd5, 4'd7, 1, 4'b1110, 0, 0};
    tbl[2] = '{0, 4'd7, 4'd1, 0, SAT ? 4'b0111 : 4'b1000, 0, 1};
    tbl[3] = '{1, 4'h8, 4'd1, 1, SAT ? 4'b1000 : 4'b0111, 1, 1};
    tbl[4] = '{0, 4'hF, 4'd1, 0, 4'b0000, 1, 0};
    tbl[5] = '{1, 4'd0, 4'd0, 1, 4'b0000, 1, 0};
    tbl[6] = '{0, 4'd4, 4'd4, 0, SAT ? 4'b0111 : 4'b1000, 0, 1};
    do_reset();
    chk("reset_outs", {gnt0, gnt1, done0, done1, res0, res1, c0, c1, v0, v1, cnt0, cnt1,
                       bas_a, bas_b, bas_m}, 0);
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].m, got);
      chk($sformatf("tbl%0d", i), got, {tbl[i].er, tbl[i].ec, tbl[i].ev});
    end
    // both requesters held from the first cycle: grants must alternate 0,1,0,1
    do_reset();
    req0 = 1; a0 = 4'd2; b0 = 4'd3; m0 = 0;
    req1 = 1; a1 = 4'd6; b1 = 4'd2; m1 = 1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      #1;
      while (!(gnt0 | gnt1) && k < 20) begin @(negedge clk); #1; k++; end
      chk("rr_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      w = gnt1;
      @(negedge clk);
      k = 1;
      while (!(w ? done1 : done0) && k < 20) begin @(negedge clk); k++; end
      chk("rr_latency", k, SETTLE + 1);
      if (w) model_done(1, 4'd6, 4'd2, 1);
      else model_done(0, 4'd2, 4'd3, 0);
      chk_state();
    end
    req0 = 0;
    req1 = 0;
    // reset in the middle of ISSUE aborts the operation
    do_reset();
    req0 = 1; a0 = 4'd1; b0 = 4'd1; m0 = 0;
    #1;
    chk("abort_gnt", gnt0, 1'b1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("abort_outs", {gnt0, gnt1, done0, done1, res0, res1, c0, c1, v0, v1, cnt0, cnt1,
                       bas_a, bas_b, bas_m}, 0);
    req0 = 0;
    @(negedge clk);
    rst = 0;
    dn = 0;
    repeat (2 * SETTLE + 4) begin @(negedge clk); dn += int'(done0) + int'(done1); end
    chk("abort_nodone", dn, 0);
    chk("abort_cnt0", cnt0, 0);
    do_op(0, 4'd2, 4'd2, 0, got);
    chk("abort_next", got, 6'b0100_00);
    // random traffic
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      rm = 1'($urandom);
      do_op(w, ra, rb, rm, got);
    end
    // counter wraps after 256 operations
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rm = 1'($urandom);
      do_op(0, ra, rb, rm, got);
    end
    chk("wrap_cnt0", cnt0, 8'd0);
    chk("wrap_cnt1", cnt1, 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
